// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl
//   Writer side of the register-file write port. Results from execute/memory
//   arrive over a valid/ready handshake, are buffered in a DEPTH-entry FIFO
//   and retired one per cycle as a registered write strobe. A pending mask
//   lets decode stall on read-after-write.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   in_valid_i/in_ready_o producer handshake (in_ready_o = !full)
//   in_dest_i, in_data_i  destination (0..3 arch, 4/5 slt temps, 6/7 illegal), value
//   wr_stall_i            register file cannot take a write this cycle
//   flush_i               discard every buffered, unissued result
//   wr_en_o, wr_addr_o,
//   wr_data_o, slt_sel_o  write strobe outputs (slt_sel 10 = t0, 11 = t1)
//   pending_mask_o        bit d set while any buffered entry targets dest d
//   drop_err_o            sticky: an illegal destination was accepted
//   count_o               FIFO occupancy
//
// Optional feature (macro WB_BYPASS_EN): a legal result accepted while the
//   FIFO is empty and idle is driven onto the write outputs combinationally in
//   the same cycle instead of being queued.
module reg_writeback_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [2:0]               in_dest_i,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic                     wr_stall_i,
  input  logic                     flush_i,
  output logic                     wr_en_o,
  output logic [1:0]               wr_addr_o,
  output logic [DATA_W-1:0]        wr_data_o,
  output logic [1:0]               slt_sel_o,
  output logic [5:0]               pending_mask_o,
  output logic                     drop_err_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;
  state_e state_q, state_d;

  logic [DEPTH-1:0][2:0]        dest_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PW-1:0]                rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]                count_q;

  logic              wr_en_q, wr_en_d;
  logic [1:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        slt_sel_q, slt_sel_d;
  logic              drop_err_q;

  logic       accept, legal, push, pop, byp;
  logic [2:0] hd;

  // Ready comes from the registered count, so a full FIFO refuses input even
  // in a cycle where it also pops.
  assign in_ready_o = (count_q != CW'(DEPTH));
  assign accept     = in_valid_i & in_ready_o;
  assign legal      = ~(in_dest_i[2] & in_dest_i[1]);

`ifdef WB_BYPASS_EN
  assign byp = accept & legal & (count_q == '0) & (state_q == IDLE) & ~wr_stall_i & ~flush_i;
`else
  assign byp = 1'b0;
`endif

  assign push = accept & legal & ~flush_i & ~byp;
  assign pop  = (state_d == ISSUE);
  assign hd   = dest_q[rd_ptr_q];

  always_comb begin
    state_d   = IDLE;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    slt_sel_d = 2'b00;
    unique case (state_q)
      IDLE, ISSUE: if (count_q != '0) state_d = wr_stall_i ? HOLD : ISSUE;
      HOLD:        state_d = wr_stall_i ? HOLD : ISSUE;
      default:     state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
    // Head entry is popped at the same edge that registers its strobe.
    if (state_d == ISSUE) begin
      wr_en_d   = ~hd[2];
      wr_addr_d = hd[1:0];
      wr_data_d = data_q[rd_ptr_q];
      slt_sel_d = hd[2] ? {1'b1, hd[0]} : 2'b00;
    end
  end

  // Slot i is live when its distance from the read pointer is below count.
  function automatic logic live(int i);
    logic [PW-1:0] off;
    off = PW'(i) - rd_ptr_q;
    return {1'b0, off} < count_q;
  endfunction

  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live(i)) pending_mask_o = pending_mask_o | (6'b1 << dest_q[i]);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      slt_sel_q  <= 2'b00;
      drop_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      slt_sel_q <= slt_sel_d;
      if (accept & ~legal) drop_err_q <= 1'b1;
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          dest_q[wr_ptr_q] <= in_dest_i;
          data_q[wr_ptr_q] <= in_data_i;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Registered outputs are quiet whenever bypass is allowed (IDLE), so a
  // plain mux is safe.
  assign wr_en_o   = byp ? ~in_dest_i[2] : wr_en_q;
  assign wr_addr_o = byp ? in_dest_i[1:0] : wr_addr_q;
  assign wr_data_o = byp ? in_data_i : wr_data_q;
  assign slt_sel_o = byp ? (in_dest_i[2] ? {1'b1, in_dest_i[0]} : 2'b00) : slt_sel_q;
`else
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign slt_sel_o = slt_sel_q;
`endif

  assign drop_err_o = drop_err_q;
  assign count_o    = count_q;
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
module tb_reg_writeback_ctrl;
  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic          clk, reset, in_valid, in_ready, wr_stall, flush;
  logic [2:0]    in_dest;
  logic [DW-1:0] in_data, wr_data;
  logic          wr_en, drop_err;
  logic [1:0]    wr_addr, slt_sel;
  logic [5:0]    pending_mask;
  logic [2:0]    count;

  reg_writeback_ctrl #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_dest_i(in_dest), .in_data_i(in_data), .wr_stall_i(wr_stall), .flush_i(flush),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .slt_sel_o(slt_sel),
    .pending_mask_o(pending_mask), .drop_err_o(drop_err), .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    d;
    logic [DW-1:0] v;
  } ent_t;

  // Reference model: every accepted legal result not yet seen on the outputs.
  ent_t q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   drop_m = 0, mon_en = 0;
  bit   p_rst = 1, p_stall = 0, p_flush = 0;
  int   p_cnt = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      bit         s;
      logic [5:0] m;
      ent_t       e;
      s = wr_en | slt_sel[1];
      // A write must appear exactly when the previous edge had queued work,
      // no stall, no flush and no reset.
      chk("strobe_timing", int'(s), int'(!p_rst && !p_stall && !p_flush && p_cnt > 0));
      if (s) begin
        if (q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          e = q.pop_front();
          chk("wr_en", int'(wr_en), int'(e.d < 3'd4));
          chk("slt_sel", int'(slt_sel), (e.d == 3'd4) ? 2 : (e.d == 3'd5) ? 3 : 0);
          if (e.d < 3'd4) chk("wr_addr", int'(wr_addr), int'(e.d));
          chk("wr_data", int'(wr_data), int'(e.v));
        end
      end
      m = '0;
      foreach (q[i]) m[q[i].d] = 1'b1;
      chk("count", int'(count), q.size());
      chk("pending_mask", int'(pending_mask), int'(m));
      chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
      chk("drop_err", int'(drop_err), int'(drop_m));
      p_cnt   = q.size();
      p_rst   = reset;
      p_stall = wr_stall;
      p_flush = flush;
    end
  end

  // One clock of stimulus; starts and ends just after a rising edge.
  task automatic cyc(bit v, logic [2:0] d, logic [DW-1:0] x, bit st, bit fl);
    bit   rdy;
    ent_t e;
    in_valid = v; in_dest = d; in_data = x; wr_stall = st; flush = fl;
    rdy = in_ready;
    @(posedge clk); #1;
    if (reset) begin
      q.delete();
      drop_m = 0;
    end else begin
      if (v && rdy && d >= 3'd6) drop_m = 1;
      if (fl) q.delete();
      else if (v && rdy && d < 3'd6) begin
        e.d = d; e.v = x;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(int n, bit st);
    for (int i = 0; i < n; i++) cyc(0, 3'd0, '0, st, 0);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_dest = 0; in_data = 0; wr_stall = 0; flush = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1;
    cyc(0, 3'd0, '0, 0, 0);
    reset = 0;
    @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_slt_sel", int'(slt_sel), 0);
    @(posedge clk); #1;

    // Single write, then 5 pushes under stall into a 4-deep FIFO.
    cyc(1, 3'd2, 8'hFE, 0, 0);
    idle(3, 0);
    for (int i = 0; i < 5; i++) cyc(1, 3'(i % 4), 8'(8'h10 + i), 1, 0);
    chk("full_count", int'(count), 4);
    idle(6, 0);

    // slt temporaries, zero data, illegal destination.
    cyc(1, 3'd4, 8'h01, 0, 0);
    cyc(1, 3'd5, 8'h00, 0, 0);
    idle(3, 0);
    cyc(1, 3'd0, 8'h00, 0, 0);
    idle(2, 0);
    cyc(1, 3'd7, 8'h99, 0, 0);
    cyc(1, 3'd1, 8'h55, 0, 0);
    idle(3, 0);
    chk("drop_sticky", int'(drop_err), 1);

    // Flush with queued entries and a same-cycle accept.
    cyc(1, 3'd0, 8'h11, 1, 0);
    cyc(1, 3'd3, 8'h22, 1, 0);
    cyc(1, 3'd5, 8'h33, 1, 0);
    cyc(1, 3'd2, 8'h44, 1, 1);
    idle(3, 0);
    cyc(1, 3'd1, 8'h66, 0, 0);
    cyc(1, 3'd3, 8'h77, 0, 1);
    idle(3, 0);

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 500; n++) begin
      logic [2:0]    d;
      logic [DW-1:0] x;
      d = ($urandom_range(0, 19) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      x = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      reset = (n == 250);
      cyc($urandom_range(0, 3) != 0, d, x, $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
    end
    reset = 0;
    idle(10, 0);
    chk("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
